tlb_op_ctrl: RTL

//  Sequences CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) onto the tlb block's search port 1 and its read/write ports.

---
 rtl/tlb_op_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR)
// onto the TLB search port 1 and the read/write ports. It also owns the Random
// counter and returns the results to CP0 as single-cycle strobes.
// Optional feature macro: TLB_WIRED_EN adds the CP0 Wired inputs
// (c0_wired, c0_wired_we), which set the lower bound of the Random counter.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,
    input  logic [IW-1:0] c0_index,
    input  logic [26:0]   c0_entryhi,
    input  logic [25:0]   c0_lo0,
    input  logic [25:0]   c0_lo1,
`ifdef TLB_WIRED_EN
    input  logic [IW-1:0] c0_wired,
    input  logic          c0_wired_we,
`endif
    input  logic [18:0]   dm_vpn2,
    input  logic          dm_odd_page,
    input  logic [7:0]    dm_asid,
    output logic          dm_stall,
    output logic [18:0]   s1_vpn2,
    output logic          s1_odd_page,
    output logic [7:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          tlb_we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1,
    output logic [IW-1:0] r_index,
    input  logic [18:0]   r_vpn2,
    input  logic [7:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_pfn0,
    input  logic [2:0]    r_c0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_pfn1,
    input  logic [2:0]    r_c1,
    input  logic          r_d1,
    input  logic          r_v1,
    output logic          idx_we,
    output logic          idx_p,
    output logic [IW-1:0] idx_val,
    output logic          rd_we,
    output logic [26:0]   rd_entryhi,
    output logic [25:0]   rd_lo0,
    output logic [25:0]   rd_lo1,
    output logic [IW-1:0] random
);

    localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t        state_reg, state_next;

    // Op register: everything EXEC needs, captured at accept so live CP0
    // changes during EXEC cannot leak into the TLB access.
    logic [1:0]    op_type_reg;
    logic [IW-1:0] op_index_reg;
    logic [IW-1:0] op_rand_reg;
    logic [26:0]   op_hi_reg;
    logic [25:0]   op_lo_reg [2];

    logic [IW-1:0] random_reg, random_next;
    logic [IW-1:0] wired;
    logic          accept;
    logic          exec_live;

    // Per-page EntryLo fields unpacked from the op register.
    logic [19:0]   lo_pfn [2];
    logic [2:0]    lo_c   [2];
    logic          lo_d   [2];
    logic          lo_v   [2];
    logic          lo_g   [2];

    assign op_ready  = (state_reg == ST_IDLE);
    assign accept    = op_valid & op_ready;
    // A reset asserted during EXEC suppresses every strobe in that same
    // cycle, so an interrupted write never reaches the TLB.
    assign exec_live = (state_reg == ST_EXEC) & resetn;
    assign random    = random_reg;

`ifdef TLB_WIRED_EN
    assign wired = c0_wired;
`else
    assign wired = '0;
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_page
        assign lo_pfn[gi] = op_lo_reg[gi][25:6];
        assign lo_c[gi]   = op_lo_reg[gi][5:3];
        assign lo_d[gi]   = op_lo_reg[gi][2];
        assign lo_v[gi]   = op_lo_reg[gi][1];
        assign lo_g[gi]   = op_lo_reg[gi][0];
    end

    // State register and op capture on accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            op_type_reg  <= '0;
            op_index_reg <= '0;
            op_rand_reg  <= '0;
            op_hi_reg    <= '0;
            op_lo_reg[0] <= '0;
            op_lo_reg[1] <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_type_reg  <= op_type;
                op_index_reg <= c0_index;
                op_rand_reg  <= random_reg;
                op_hi_reg    <= c0_entryhi;
                op_lo_reg[0] <= c0_lo0;
                op_lo_reg[1] <= c0_lo1;
            end
        end
    end

    // Next state: every accepted op spends exactly one cycle in EXEC.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (op_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // EXEC actions: drive TLB ports and CP0 strobes from the op register.
    always_comb begin
        op_done     = 1'b0;
        tlb_we      = 1'b0;
        idx_we      = 1'b0;
        rd_we       = 1'b0;
        dm_stall    = 1'b0;
        s1_vpn2     = dm_vpn2;
        s1_odd_page = dm_odd_page;
        s1_asid     = dm_asid;
        w_index     = '0;
        w_vpn2      = '0;
        w_asid      = '0;
        w_g         = 1'b0;
        w_pfn0      = '0;
        w_c0        = '0;
        w_d0        = 1'b0;
        w_v0        = 1'b0;
        w_pfn1      = '0;
        w_c1        = '0;
        w_d1        = 1'b0;
        w_v1        = 1'b0;
        r_index     = '0;
        idx_p       = 1'b0;
        idx_val     = '0;
        rd_entryhi  = '0;
        rd_lo0      = '0;
        rd_lo1      = '0;
        if (exec_live) begin
            op_done = 1'b1;
            case (op_type_reg)
                OP_TLBP: begin
                    dm_stall    = 1'b1;
                    s1_vpn2     = op_hi_reg[26:8];
                    s1_odd_page = 1'b0;
                    s1_asid     = op_hi_reg[7:0];
                    idx_we      = 1'b1;
                    idx_p       = ~s1_found;
                    idx_val     = s1_found ? s1_index : '0;
                end
                OP_TLBR: begin
                    r_index    = op_index_reg;
                    rd_we      = 1'b1;
                    rd_entryhi = {r_vpn2, r_asid};
                    rd_lo0     = {r_pfn0, r_c0, r_d0, r_v0, r_g};
                    rd_lo1     = {r_pfn1, r_c1, r_d1, r_v1, r_g};
                end
                OP_TLBWI, OP_TLBWR: begin
                    tlb_we  = 1'b1;
                    w_index = (op_type_reg == OP_TLBWR) ? op_rand_reg : op_index_reg;
                    w_vpn2  = op_hi_reg[26:8];
                    w_asid  = op_hi_reg[7:0];
                    w_g     = lo_g[0] & lo_g[1];
                    w_pfn0  = lo_pfn[0];
                    w_c0    = lo_c[0];
                    w_d0    = lo_d[0];
                    w_v0    = lo_v[0];
                    w_pfn1  = lo_pfn[1];
                    w_c1    = lo_c[1];
                    w_d1    = lo_d[1];
                    w_v1    = lo_v[1];
                end
                default: ;
            endcase
        end
    end

    // Random next value: count down, wrapping to the top once it reaches
    // wired. Using <= also pins it at the top when wired is at or above it.
    always_comb begin
        random_next = (random_reg <= wired) ? RAND_TOP : random_reg - 1'b1;
`ifdef TLB_WIRED_EN
        if (c0_wired_we) begin
            random_next = RAND_TOP;
        end
`endif
    end

    // Random register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            random_reg <= RAND_TOP;
        end else begin
            random_reg <= random_next;
        end
    end

endmodule
